fetch_unit: RTL

- Instruction fetch stage upstream of the single-cycle datapath.
- Issues word requests to a variable-latency instruction memory port and buffers returned words in a small in-order prefetch FIFO.
- Presents `instruction` and `inst_pc` to the datapath/decoder through a valid/ready handshake.
- Branch, jal and jalr targets arrive as a redirect. Fetch flushes and restarts at the target, discarding stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   localparam logic [31:0] NOP_WORD     = 32'h0000_0013;
   localparam int          DEF_DEPTH    = 4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response port plus the decoder-side handshake and redirect.
interface fetch_unit_if #(
   parameter int W = 32
);
   logic          mem_req;
   logic [W-1:0]  mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;
   logic          redirect;
   logic [W-1:0]  redirect_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic [31:0]   instruction;
   logic [W-1:0]  inst_pc;

   modport master (
      output mem_req, mem_addr, inst_valid, instruction, inst_pc,
      input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  mem_req, mem_addr, inst_valid, instruction, inst_pc,
      output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO with wrap-bit pointers and a registered head that holds when empty.
module fetch_fifo #(
   parameter  int DEPTH = 4,
   parameter  int DW    = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] push_data,
   output logic [AW:0]   count,
   output logic [DW-1:0] head
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt, live;
   logic [DW-1:0] head_nxt;

   assign count = wr_ptr - rd_ptr;

   // The head register looks one step ahead so a freshly pushed word is visible next cycle.
   always_comb begin
      rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
      wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
      if (flush) begin
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
      end
      count_nxt = wr_ptr_nxt - rd_ptr_nxt;
      live      = count - {{AW{1'b0}}, pop};
      head_nxt  = head;
      if (count_nxt != '0)
         head_nxt = (live == '0) ? push_data : mem[rd_ptr_nxt[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         head   <= head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues word requests, buffers in-order responses, and flushes stale
// in-flight words after a branch/jump redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int           W        = 32,
   parameter int           DEPTH    = DEF_DEPTH,
   parameter logic [W-1:0] RESET_PC = W'(DEF_RESET_PC)
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state, state_nxt;
   logic          run_en;
   logic [W-1:0]  fetch_pc, resp_pc, target;
   logic [CW-1:0] outstanding, out_nxt, stale, stale_nxt, count;
   logic [CW:0]   occ;
   logic          grant, resp, push, pop;
   logic [W+31:0] head;

   assign target  = bus.redirect_pc & ~W'(3);
   assign grant   = bus.mem_req & bus.mem_gnt;
   assign resp    = bus.mem_rvalid & (outstanding != '0);
   assign push    = resp & (stale == '0) & ~bus.redirect;
   assign pop     = bus.inst_valid & bus.inst_ready & ~bus.redirect;
   assign out_nxt = outstanding + CW'(grant) - CW'(resp);
   assign occ     = {1'b0, count} + {1'b0, outstanding};

   // A redirect marks every request still in flight after this edge as stale,
   // including one granted on the old path in the same cycle.
   always_comb begin
      stale_nxt = stale;
      if (bus.redirect)
         stale_nxt = out_nxt;
      else if (resp && stale != '0)
         stale_nxt = stale - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.redirect)
         state_nxt = (out_nxt != '0) ? FLUSH : RUN;
      else if (state == FLUSH && stale_nxt == '0)
         state_nxt = RUN;
   end

   always_comb begin
      bus.mem_req = 1'b0;
      if (state == RUN && run_en)
         bus.mem_req = (occ < (CW+1)'(DEPTH));
   end

   // run_en keeps mem_req low while reset is held without a combinational path from rst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_en      <= 1'b0;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         stale       <= '0;
      end else begin
         run_en      <= 1'b1;
         outstanding <= out_nxt;
         stale       <= stale_nxt;
         if (bus.redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
         end else begin
            if (grant) fetch_pc <= fetch_pc + W'(4);
            if (push)  resp_pc  <= resp_pc + W'(4);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .DW    (W + 32)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (bus.redirect),
      .push_data ({bus.mem_rdata, resp_pc}),
      .count     (count),
      .head      (head)
   );

   assign bus.mem_addr    = fetch_pc;
   assign bus.inst_valid  = (count != '0);
   assign bus.instruction = head[W+31:W];
   assign bus.inst_pc     = head[W-1:0];

endmodule
